// File: rtl/multiplexador_br_arbitrado.sv
// rtl/multiplexador_br_arbitrado.sv - N-channel registered write-back mux with direct or round-robin selection
module multiplexador_br_arbitrado #(
    parameter  int LARGURA = 32,
    parameter  int CANAIS  = 4,
    localparam int SEL_W   = (CANAIS > 1) ? $clog2(CANAIS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      modo,
    input  logic [SEL_W-1:0]          flag,
    input  logic [CANAIS*LARGURA-1:0] entradas,
    input  logic [CANAIS-1:0]         entradas_validas,
    output logic [CANAIS-1:0]         entradas_prontas,
    output logic [LARGURA-1:0]        saida,
    output logic                      saida_valida,
    input  logic                      saida_pronta,
    output logic [SEL_W-1:0]          canal_saida
);

    logic [LARGURA-1:0] saida_q, saida_d;
    logic               valida_q, valida_d;
    logic [SEL_W-1:0]   canal_q, canal_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic               carregar;
    logic               tem_grant;
    logic [SEL_W-1:0]   g;
    logic [SEL_W-1:0]   idx_s;
    int                 idx;

    assign carregar = !valida_q || saida_pronta;

    // Grant selection: flag lookup in direct mode, first valid channel from ptr in round-robin mode
    always_comb begin
        tem_grant = 1'b0;
        g         = '0;
        idx       = 0;
        idx_s     = '0;
        if (!modo) begin
            if (int'(flag) < CANAIS) begin
                if (entradas_validas[flag]) begin
                    tem_grant = 1'b1;
                    g         = flag;
                end
            end
        end else begin
            // Walk backwards so the channel closest to ptr is the last (winning) assignment
            for (int k = CANAIS - 1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= CANAIS) begin
                    idx = idx - CANAIS;
                end
                idx_s = SEL_W'(idx);
                if (entradas_validas[idx_s]) begin
                    tem_grant = 1'b1;
                    g         = idx_s;
                end
            end
        end
    end

    // Accept strobe: only the granted channel, only when the output stage can load, never during reset
    always_comb begin
        entradas_prontas = '0;
        if (tem_grant && carregar && !reset) begin
            entradas_prontas[g] = 1'b1;
        end
    end

    // Next state of the output stage and round-robin pointer
    always_comb begin
        saida_d  = saida_q;
        valida_d = valida_q;
        canal_d  = canal_q;
        ptr_d    = ptr_q;
        if (tem_grant && carregar) begin
            saida_d  = entradas[int'(g)*LARGURA +: LARGURA];
            canal_d  = g;
            valida_d = 1'b1;
            if (modo) begin
                ptr_d = (int'(g) == CANAIS - 1) ? '0 : g + SEL_W'(1);
            end
        end else if (saida_pronta) begin
            valida_d = 1'b0;
        end
    end

    // Output register and pointer, cleared immediately on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            saida_q  <= '0;
            valida_q <= 1'b0;
            canal_q  <= '0;
            ptr_q    <= '0;
        end else begin
            saida_q  <= saida_d;
            valida_q <= valida_d;
            canal_q  <= canal_d;
            ptr_q    <= ptr_d;
        end
    end

    assign saida        = saida_q;
    assign saida_valida = valida_q;
    assign canal_saida  = canal_q;

endmodule

// File: tb/tb_multiplexador_br_arbitrado.sv
// tb/tb_multiplexador_br_arbitrado.sv - bench for multiplexador_br_arbitrado with 4- and 3-channel instances
module tb_multiplexador_br_arbitrado;

    logic         clock = 1'b0;
    logic         reset;
    logic         modo;
    logic [1:0]   flag;
    logic [127:0] entradas;
    logic [3:0]   validas;
    logic         pronta;

    logic [3:0]   p4;
    logic [31:0]  s4;
    logic         sv4;
    logic [1:0]   c4;
    logic [2:0]   p3;
    logic [31:0]  s3;
    logic         sv3;
    logic [1:0]   c3;

    int total = 0;
    int bad   = 0;

    int          n_c   [2] = '{4, 3};
    logic        m_val [2];
    logic [31:0] m_dat [2];
    int          m_ch  [2];
    int          m_ptr [2];

    always #5 clock = ~clock;

    multiplexador_br_arbitrado #(.LARGURA(32), .CANAIS(4)) dut4 (
        .clock(clock), .reset(reset), .modo(modo), .flag(flag),
        .entradas(entradas), .entradas_validas(validas), .entradas_prontas(p4),
        .saida(s4), .saida_valida(sv4), .saida_pronta(pronta), .canal_saida(c4)
    );

    multiplexador_br_arbitrado #(.LARGURA(32), .CANAIS(3)) dut3 (
        .clock(clock), .reset(reset), .modo(modo), .flag(flag),
        .entradas(entradas[95:0]), .entradas_validas(validas[2:0]), .entradas_prontas(p3),
        .saida(s3), .saida_valida(sv3), .saida_pronta(pronta), .canal_saida(c3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int grant(input int n, input logic md, input logic [1:0] fl,
                                 input logic [3:0] v, input int p);
        if (!md) begin
            if (int'(fl) < n && v[fl]) return int'(fl);
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            int c;
            c = (p + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [31:0] dato(input int c);
        logic [127:0] e;
        e = entradas;
        return e[c*32 +: 32];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 1'b0;
            m_dat[k] = '0;
            m_ch[k]  = 0;
            m_ptr[k] = 0;
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            int   g;
            logic carr;
            logic [3:0] expp;
            g    = grant(n_c[k], modo, flag, validas, m_ptr[k]);
            carr = !m_val[k] || pronta;
            expp = (g >= 0 && carr) ? 4'(1 << g) : 4'b0000;
            if (k == 0) begin
                chk("m4 prontas", 64'(p4), 64'(expp));
                chk("m4 valida", 64'(sv4), 64'(m_val[k]));
                chk("m4 saida", 64'(s4), 64'(m_dat[k]));
                chk("m4 canal", 64'(c4), 64'(m_ch[k]));
            end else begin
                chk("m3 prontas", 64'(p3), 64'(expp[2:0]));
                chk("m3 valida", 64'(sv3), 64'(m_val[k]));
                chk("m3 saida", 64'(s3), 64'(m_dat[k]));
                chk("m3 canal", 64'(c3), 64'(m_ch[k]));
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int   g;
            logic carr;
            g    = grant(n_c[k], modo, flag, validas, m_ptr[k]);
            carr = !m_val[k] || pronta;
            if (g >= 0 && carr) begin
                m_dat[k] = dato(g);
                m_ch[k]  = g;
                m_val[k] = 1'b1;
                if (modo) m_ptr[k] = (g + 1) % n_c[k];
            end else if (pronta) begin
                m_val[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(negedge clock);
        model_check();
        @(posedge clock);
        if (!reset) model_update();
        #1;
    endtask

    task automatic set_data(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        entradas = {d3, d2, d1, d0};
    endtask

    initial begin
        reset   = 1'b1;
        modo    = 1'b0;
        flag    = 2'd0;
        validas = 4'b1111;
        pronta  = 1'b1;
        set_data(32'h1, 32'h2, 32'h3, 32'h4);
        model_reset();
        #1;
        chk("reset saida", 64'(s4), 64'h0);
        chk("reset valida", 64'(sv4), 64'h0);
        chk("reset canal", 64'(c4), 64'h0);
        chk("reset prontas", 64'(p4), 64'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Direct selection of channel 2
        modo = 1'b0; flag = 2'd2; validas = 4'b0100; pronta = 1'b1;
        set_data(32'h0, 32'h0, 32'hDEADBEEF, 32'h0);
        #1 chk("direct prontas", 64'(p4), 64'b0100);
        step();
        chk("direct saida", 64'(s4), 64'hDEADBEEF);
        chk("direct canal", 64'(c4), 64'd2);
        chk("direct valida", 64'(sv4), 64'd1);

        // Flag points to a non-valid channel
        flag = 2'd1;
        #1 chk("noval prontas", 64'(p4), 64'b0000);
        step();
        chk("noval valida", 64'(sv4), 64'd0);

        // Backpressure
        flag = 2'd0; validas = 4'b0001; set_data(32'h11, 32'h0, 32'h0, 32'h0);
        step();
        pronta = 1'b0; set_data(32'h22, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp prontas", 64'(p4), 64'b0000);
            step();
            chk("bp saida", 64'(s4), 64'h11);
        end
        pronta = 1'b1;
        #1 chk("bp release prontas", 64'(p4), 64'b0001);
        step();
        chk("bp release saida", 64'(s4), 64'h22);

        // Round-robin fairness with all channels valid
        modo = 1'b1; validas = 4'b1111;
        set_data(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr canal", 64'(c4), 64'(i % 4));
            chk("rr saida", 64'(s4), 64'(32'hA0 + (i % 4)));
            chk("rr valida", 64'(sv4), 64'd1);
        end

        // Wrap and skip: move dut4 ptr to 3, then only ch1 valid
        validas = 4'b0100;
        step();
        validas = 4'b0010;
        #1 chk("skip prontas", 64'(p4), 64'b0010);
        step();
        chk("skip canal", 64'(c4), 64'd1);
        validas = 4'b1111;
        #1 chk("ptr after skip", 64'(p4), 64'b0100);
        chk("ptr3 at 2", 64'(p3), 64'b100);
        validas = 4'b0001;
        #1 chk("wrap3 prontas", 64'(p3), 64'b001);
        step();
        chk("wrap3 canal", 64'(c3), 64'd0);

        // Out-of-range flag on the 3-channel instance, then switch to round-robin
        modo = 1'b0; flag = 2'd3; validas = 4'b1111; pronta = 1'b0;
        #1 chk("oor prontas", 64'(p3), 64'b000);
        step();
        chk("oor hold saida", 64'(s3), 64'hA0);
        modo = 1'b1; pronta = 1'b1;
        #1 chk("switch prontas", 64'(p3), 64'b010);
        chk("switch saida held", 64'(s3), 64'hA0);
        step();
        chk("switch canal", 64'(c3), 64'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            modo    = 1'($urandom);
            flag    = 2'($urandom);
            validas = 4'($urandom);
            pronta  = ($urandom_range(0, 3) != 0);
            set_data($urandom, $urandom, $urandom, $urandom);
            step();
        end

        // Reset while holding data
        modo = 1'b1; validas = 4'b1111; pronta = 1'b0;
        step();
        chk("pre-reset valida", 64'(sv4), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset saida", 64'(s4), 64'h0);
        chk("midreset valida", 64'(sv4), 64'h0);
        chk("midreset canal", 64'(c4), 64'h0);
        chk("midreset prontas4", 64'(p4), 64'h0);
        chk("midreset prontas3", 64'(p3), 64'h0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        pronta = 1'b1;
        #1 chk("post-reset ptr", 64'(p4), 64'b0001);
        for (int i = 0; i < 20; i++) begin
            validas = 4'($urandom);
            set_data($urandom, $urandom, $urandom, $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiplexador_br_arbitrado.md
Name: multiplexador_br_arbitrado

Overview:
- Parametrised N-channel, registered successor to the 2:1 register-bank write-back multiplexer.
- Selects one of CANAIS data sources for the register-bank write port and captures it in one output register stage.
- Each input channel and the output use a valid/ready handshake.
- Two selection modes: direct selection by flag, or round-robin arbitration among requesting channels for shared write-back.

Parameters:
- LARGURA, 32, data width of each channel and of the output.
- CANAIS, 4, number of input channels (>=1, need not be a power of two).
- SEL_W, derived as max(1, clog2(CANAIS)); local, not overridable; width of the channel index.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- modo  input  1  0 = direct selection by flag; 1 = round-robin arbitration.
- flag  input  SEL_W  channel index used when modo=0.
- entradas  input  CANAIS*LARGURA  flattened channel data; channel i is bits [i*LARGURA +: LARGURA].
- entradas_validas  input  CANAIS  per-channel valid.
- entradas_prontas  output  CANAIS  per-channel accept (grant), combinational, one-hot or zero.
- saida  output  LARGURA  registered selected data.
- saida_valida  output  1  saida holds unconsumed data.
- saida_pronta  input  1  consumer (register bank) accepts saida this cycle.
- canal_saida  output  SEL_W  index of the channel whose data is in saida.

Behaviour:
- Reset (async, immediate): saida=0, saida_valida=0, canal_saida=0, round-robin pointer ptr=0. entradas_prontas=0 while reset is high.
- carregar = !saida_valida | saida_pronta. The output register may load only when carregar=1.
- Grant g is computed combinationally each cycle:
  - modo=0: g=flag if flag<CANAIS and entradas_validas[flag]=1. No grant if flag>=CANAIS (out-of-range) or that channel is not valid.
  - modo=1: search channels ptr, ptr+1, ..., wrapping modulo CANAIS (wraps at CANAIS-1 -> 0, also for non-power-of-two CANAIS). g = first channel with valid=1. No grant if no channel is valid.
- entradas_prontas[g]=1 only when a grant exists and carregar=1. All other bits are 0.
- A transfer on channel i occurs when entradas_validas[i] & entradas_prontas[i]. At most one transfer per cycle.
- On a transfer, at the clock edge: saida <= entradas[g], canal_saida <= g, saida_valida <= 1.
- Else if saida_pronta=1: saida_valida <= 0; saida and canal_saida hold their last value.
- Else: all outputs hold. While saida_valida=1 and saida_pronta=0, saida and canal_saida must be stable.
- Latency: data accepted in cycle n appears on saida with saida_valida=1 in cycle n+1.
- Throughput: 1 word per cycle. A simultaneous drain (saida_pronta=1) and new transfer in the same cycle is allowed with no bubble.
- Round-robin pointer: on a transfer in modo=1, ptr <= (g+1) mod CANAIS. ptr is unchanged when there is no transfer and unchanged in modo=0.
- Changing modo or flag takes effect in the same cycle for grant computation; data already held in saida is unaffected.
- CANAIS=1: both modes always select channel 0 (flag must be 0 in modo=0); ptr stays 0.
- Reset asserted mid-transfer: held data is discarded and saida_valida drops immediately. Inputs are not acknowledged while reset is high.

Test Plan:
- Reset/idle: assert reset with saida_valida=1 mid-stream -> saida=0, saida_valida=0, canal_saida=0 immediately, without waiting for a clock edge; entradas_prontas=0.
- Direct mode, CANAIS=4, LARGURA=32: modo=0, flag=2, ch2=0xDEADBEEF valid, saida_pronta=1 -> entradas_prontas=4'b0100; next cycle saida=0xDEADBEEF, canal_saida=2, saida_valida=1. Repeat with flag=1 while ch1 is not valid -> no grant, saida_valida drops to 0.
- Backpressure: output holding 0x11 with saida_pronta=0, ch0 valid with 0x22 -> entradas_prontas=0 and saida stays 0x11 for 5 cycles. Raise saida_pronta -> same cycle entradas_prontas[0]=1; next cycle saida=0x22.
- Round-robin fairness: modo=1, all 4 channels valid continuously (data 0xA0..0xA3), saida_pronta=1 -> canal_saida sequence 0,1,2,3,0,1, one word per cycle with no bubbles.
- Round-robin wrap/skip: ptr=3, only ch1 valid -> grant ch1, then ptr=2. With CANAIS=3 and ptr=2, only ch0 valid -> grant ch0 (wrap at 2 -> 0).
- Mode switch and out-of-range flag: modo=0, flag=3 with CANAIS=3 -> no grant even with all channels valid. Switch to modo=1 the next cycle -> grant follows ptr that same cycle, and held output data is unchanged at the switch.
